// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-mux encoding,
// controller FSM states and the register-number width.
package hazard_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Priority compare for one EXE source operand: the younger MEM result beats
// the older WB result, otherwise the register-file value is used.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_valid,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  wb_wb_en,
  output fwd_sel_t              sel
);

  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = FWD_REG;
    if (src_valid && mem_wb_en && (src == mem_dest)) begin
      sel = FWD_MEM;
    end else if (src_valid && wb_wb_en && (src == wb_dest)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall / flush / freeze and forwarding control around the EXE stage.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt / flush_cnt counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter bit FWD_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_valid,
  input  logic                  id_src2_valid,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  wb_wb_en,
  output logic [1:0]            alu_mux_sel_src1,
  output logic [1:0]            alu_mux_sel_src2,
  output logic                  freeze_if,
  output logic                  freeze_id,
  output logic                  bubble_exe,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic                  freeze_all,
  output logic                  mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  hz_state_t             state, state_next;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_inc;
  logic [REG_ADDR_W-1:0] exe_src1, exe_src2;
  logic                  exe_src1_valid, exe_src2_valid;
  logic                  hit1_exe, hit2_exe, hit1_mem, hit2_mem;
  logic                  stall_raw, stall;
  fwd_sel_t              sel1, sel2;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state avoid race ordering.
    if (rst) state <= HZ_RUN;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      HZ_RUN:      if (mem_req && !mem_ready) state_next = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (mem_ready)             state_next = HZ_RUN;
      default:                                state_next = HZ_RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    hit1_exe = id_src1_valid && (id_src1 == exe_dest);
    hit2_exe = id_src2_valid && (id_src2 == exe_dest);
    hit1_mem = id_src1_valid && (id_src1 == mem_dest);
    hit2_mem = id_src2_valid && (id_src2 == mem_dest);
    // Without forwarding any in-flight EXE/MEM writer must drain; WB is
    // written before the register file is read, so it never stalls.
    if (FWD_EN) stall_raw = exe_mem_r_en && exe_wb_en && (hit1_exe || hit2_exe);
    else        stall_raw = (exe_wb_en && (hit1_exe || hit2_exe)) ||
                            (mem_wb_en && (hit1_mem || hit2_mem));
    stall        = stall_raw && !branch_taken;
    freeze_all   = mem_req && !mem_ready;
    freeze_if    = freeze_all || stall;
    freeze_id    = freeze_all || stall;
    bubble_exe   = stall && !freeze_all;
    flush_if_id  = branch_taken && !freeze_all;
    flush_id_exe = branch_taken && !freeze_all;
  end

  // SRAM wait counter and sticky timeout flag.
  assign wait_cnt_inc = wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else if (state == HZ_MEM_WAIT) begin
      if (mem_ready) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == CNT_MAX) mem_timeout_err <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Source registers of the instruction entering EXE.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_src1       <= '0;
      exe_src2       <= '0;
      exe_src1_valid <= 1'b0;
      exe_src2_valid <= 1'b0;
    end else if (!freeze_all) begin
      if (bubble_exe || flush_id_exe) begin
        exe_src1_valid <= 1'b0;
        exe_src2_valid <= 1'b0;
      end else begin
        exe_src1       <= id_src1;
        exe_src2       <= id_src2;
        exe_src1_valid <= id_src1_valid;
        exe_src2_valid <= id_src2_valid;
      end
    end
  end

  fwd_select u_fwd_src1 (
    .src       (exe_src1),
    .src_valid (exe_src1_valid),
    .mem_dest  (mem_dest),
    .mem_wb_en (mem_wb_en),
    .wb_dest   (wb_dest),
    .wb_wb_en  (wb_wb_en),
    .sel       (sel1)
  );

  fwd_select u_fwd_src2 (
    .src       (exe_src2),
    .src_valid (exe_src2_valid),
    .mem_dest  (mem_dest),
    .mem_wb_en (mem_wb_en),
    .wb_dest   (wb_dest),
    .wb_wb_en  (wb_wb_en),
    .sel       (sel2)
  );

  assign alu_mux_sel_src1 = FWD_EN ? sel1 : FWD_REG;
  assign alu_mux_sel_src2 = FWD_EN ? sel2 : FWD_REG;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze_if)    stall_cnt <= stall_cnt + 32'd1;
      if (flush_id_exe) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
